// File: rtl/sdrc_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller user interface: same command/ack/burst timing, no real SDRAM.
// Latency: ack one cycle after accept; read word k appears CasLatency+1+k cycles after accept.
// Backpressure: commands are taken only in IDLE after init with power-down/self-refresh low; otherwise ignored.
// Ports: clk/rst_n (sync, active-low); I_sdrc_* command, address, mask, write data and burst length;
//        I_sdram_power_down/selfrefresh gate new commands; O_sdrc_data read data, O_sdrc_init_done, O_sdrc_cmd_ack.
module sdrc_bram_responder #(
    parameter int AddressBitWidth = 12,
    parameter int InitCycles      = 16,
    parameter int CasLatency      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack
);

    localparam int IW       = $clog2(InitCycles + 1);
    localparam int WW       = (CasLatency > 1) ? $clog2(CasLatency) : 1;
    localparam int WaitLast = (CasLatency > 1) ? CasLatency - 2 : 0;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACK, S_WRITE, S_READ_WAIT, S_READ
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [IW-1:0] r_init_cnt;
    logic        r_init_done;
    logic        r_ack;
    logic [31:0] r_data;
    logic [1:0]  r_bank;
    logic [7:0]  r_col;
    logic [7:0]  r_len;
    logic [8:0]  r_cnt;      // burst word index; reads run one step past the last word
    logic [WW-1:0] r_wait;
    logic [10:0] r_row [4];
    logic [31:0] r_mem [0:(1 << AddressBitWidth) - 1];

    logic        w_init_last;
    logic        w_accept;
    logic        w_ack_go;
    logic        w_we;
    logic        w_rd;
    logic [7:0]  w_col;
    logic [20:0] w_full;
    logic [AddressBitWidth-1:0] w_addr;
    logic        w_unused;

    assign w_init_last = !r_init_done && (r_init_cnt == IW'(InitCycles - 1));
    // Column wraps inside the row; bank and row never advance during a burst.
    assign w_col  = r_col + r_cnt[7:0];
    assign w_full = {r_bank, r_row[r_bank], w_col};
    assign w_addr = w_full[AddressBitWidth-1:0];
    assign w_unused = &{1'b0, I_sdrc_precharge_ctrl, w_full};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack_go    = 1'b0;
        w_we        = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            S_INIT: begin
                if (w_init_last) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (I_sdrc_cmd_en && r_init_done && !I_sdram_power_down && !I_sdram_selfrefresh) begin
                    w_accept = 1'b1;
                    case (I_sdrc_cmd)
                        3'b100:         begin w_state_nxt = S_WRITE; w_ack_go = 1'b1; end
                        3'b101:         begin
                                            w_state_nxt = (CasLatency > 1) ? S_READ_WAIT : S_READ;
                                            w_ack_go    = 1'b1;
                                        end
                        3'b110, 3'b111: w_state_nxt = S_IDLE;
                        default:        begin w_state_nxt = S_ACK; w_ack_go = 1'b1; end
                    endcase
                end
            end
            S_ACK: w_state_nxt = S_IDLE;
            S_WRITE: begin
                w_we = 1'b1;
                if (r_cnt[7:0] == r_len) w_state_nxt = S_IDLE;
            end
            S_READ_WAIT: begin
                if (r_wait == WW'(WaitLast)) w_state_nxt = S_READ;
            end
            S_READ: begin
                // Extra step after the last word keeps IDLE one cycle behind the data, like writes.
                if (r_cnt == ({1'b0, r_len} + 9'd1)) w_state_nxt = S_IDLE;
                else                                 w_rd = 1'b1;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_ack       <= 1'b0;
            r_data      <= '0;
            r_bank      <= '0;
            r_col       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_wait      <= '0;
            for (int i = 0; i < 4; i++) r_row[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_go;
            if (!r_init_done) r_init_cnt <= r_init_cnt + 1'b1;
            if (w_init_last)  r_init_done <= 1'b1;
            if (w_accept) begin
                r_bank <= I_sdrc_addr[20:19];
                r_col  <= I_sdrc_addr[7:0];
                r_len  <= I_sdrc_data_len;
                r_cnt  <= '0;
                r_wait <= '0;
                if (I_sdrc_cmd == 3'b011) r_row[I_sdrc_addr[20:19]] <= I_sdrc_addr[18:8];
            end
            if (r_state == S_READ_WAIT) r_wait <= r_wait + 1'b1;
            if (w_we) r_cnt <= r_cnt + 9'd1;
            if (w_rd) begin
                r_data <= r_mem[w_addr];
                r_cnt  <= r_cnt + 9'd1;
            end
        end
    end

    // No reset on the array; the rst_n gate stops a cut-off burst from writing on the reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) r_mem[w_addr][8*b +: 8] <= I_sdrc_data[8*b +: 8];
            end
        end
    end

    assign O_sdrc_data      = r_data;
    assign O_sdrc_init_done = r_init_done;
    assign O_sdrc_cmd_ack   = r_ack;

endmodule

// File: tb/tb_sdrc_bram_responder.sv
module tb_sdrc_bram_responder;

    localparam int AW = 12;
    localparam int IC = 16;
    localparam int CL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd = 3'b111;
    logic        pchg = 1'b0;
    logic        pd = 1'b0;
    logic        sr = 1'b0;
    logic [20:0] addr = '0;
    logic [3:0]  dqm = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  dlen = '0;
    logic [31:0] o_data;
    logic        o_init_done;
    logic        o_ack;

    sdrc_bram_responder #(.AddressBitWidth(AW), .InitCycles(IC), .CasLatency(CL)) dut (
        .clk(clk), .rst_n(rst_n),
        .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd), .I_sdrc_precharge_ctrl(pchg),
        .I_sdram_power_down(pd), .I_sdram_selfrefresh(sr),
        .I_sdrc_addr(addr), .I_sdrc_dqm(dqm), .I_sdrc_data(wdata), .I_sdrc_data_len(dlen),
        .O_sdrc_data(o_data), .O_sdrc_init_done(o_init_done), .O_sdrc_cmd_ack(o_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; logic [31:0] val; } rd_t;
    rd_t         rdq[$];
    int          ackq[$];
    logic [31:0] mdl[int];
    int          rows[4];
    int          next_ok = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wd[256];
    logic [3:0]  wm[256];

    function automatic int waddr(input int bank, input int row, input int col);
        return ((bank << 19) | (row << 8) | (col % 256)) % (1 << AW);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: ack must appear exactly at the cycles the stimulus predicted; read words at their slots.
    initial begin
        forever begin
            logic exp_ack;
            @(posedge clk);
            #1;
            exp_ack = (ackq.size() > 0 && ackq[0] == cyc);
            if (o_ack || exp_ack) begin
                checks++;
                if (o_ack !== exp_ack) begin
                    errors++;
                    $display("FAIL ack: got %b expected %b (cycle %0d)", o_ack, exp_ack, cyc);
                end
                if (exp_ack) void'(ackq.pop_front());
            end
            while (ackq.size() > 0 && ackq[0] < cyc) void'(ackq.pop_front());
            if (rdq.size() > 0 && rdq[0].at == cyc) begin
                chk("read_data", o_data, rdq[0].val);
                void'(rdq.pop_front());
            end
        end
    end

    task automatic wait_ok();
        while (cyc + 1 < next_ok) @(negedge clk);
    endtask

    // Issue one command; called and returns just after a falling edge.
    task automatic issue(input logic [2:0] c, input logic [20:0] a, input logic [7:0] len, output int n);
        wait_ok();
        cmd_en = 1'b1; cmd = c; addr = a; dlen = len;
        n = cyc + 1;
        if (c[2:1] != 2'b11) ackq.push_back(n);
        case (c)
            3'b011:         begin rows[a[20:19]] = int'(a[18:8]); next_ok = n + 2; end
            3'b100:         next_ok = n + 2 + int'(len);
            3'b101:         next_ok = n + CL + int'(len) + 2;
            3'b110, 3'b111: next_ok = n + 1;
            default:        next_ok = n + 2;
        endcase
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    task automatic activate(input int bank, input int row);
        int n;
        issue(3'b011, {bank[1:0], row[10:0], 8'h00}, 8'd0, n);
    endtask

    task automatic model_write(input int bank, input int col, input logic [31:0] d, input logic [3:0] m);
        int a;
        logic [31:0] v;
        a = waddr(bank, rows[bank], col);
        v = mdl.exists(a) ? mdl[a] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (!m[b]) v[8*b +: 8] = d[8*b +: 8];
        mdl[a] = v;
    endtask

    task automatic write_burst(input int bank, input int col, input int len);
        int n;
        issue(3'b100, {bank[1:0], 11'd0, col[7:0]}, len[7:0], n);
        for (int k = 0; k <= len; k++) begin
            wdata = wd[k]; dqm = wm[k];
            model_write(bank, col + k, wd[k], wm[k]);
            @(negedge clk);
        end
    endtask

    task automatic read_burst(input int bank, input int col, input int len, input bit hold_en);
        int n;
        int a;
        rd_t e;
        issue(3'b101, {bank[1:0], 11'd0, col[7:0]}, len[7:0], n);
        for (int k = 0; k <= len; k++) begin
            a = waddr(bank, rows[bank], col + k);
            e.at = n + CL + k;
            e.val = mdl[a];
            rdq.push_back(e);
        end
        if (hold_en) begin
            cmd_en = 1'b1; cmd = 3'b100;
            while (cyc + 1 < next_ok) @(negedge clk);
            cmd_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        int e1;
        rst_n = 1'b0; cmd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_init_done", {31'd0, o_init_done}, 32'd0);
        chk("reset_data", o_data, 32'd0);
        chk("reset_ack", {31'd0, o_ack}, 32'd0);
        ackq.delete();
        for (int i = 0; i < 4; i++) rows[i] = 0;
        cmd_en = 1'b1; cmd = 3'b011; addr = 21'h0_0100;
        rst_n = 1'b1;
        e1 = cyc + 1;
        for (int i = 0; i < IC; i++) begin
            @(posedge clk);
            #1;
            chk("init_done_timing", {31'd0, o_init_done}, (i == IC - 1) ? 32'd1 : 32'd0);
        end
        cmd_en = 1'b0;
        next_ok = e1 + IC;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        // Burst wrapping from column FE through 01 inside row 0x0A5.
        activate(0, 11'h0A5);
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h1111_1111 * (k + 1); wm[k] = 4'h0; end
        write_burst(0, 8'hFE, 3);
        read_burst(0, 8'hFE, 3, 1'b0);

        // Byte masking over a cleared word.
        wd[0] = 32'h0; wm[0] = 4'h0;
        write_burst(0, 8'h40, 0);
        wd[0] = 32'hAABB_CCDD; wm[0] = 4'b0101;
        write_burst(0, 8'h40, 0);
        read_burst(0, 8'h40, 0, 1'b0);

        // Two banks with different open rows must not alias.
        activate(1, 5);
        activate(2, 9);
        wd[0] = 32'hB1B1_0005; wm[0] = 4'h0;
        write_burst(1, 3, 0);
        wd[0] = 32'hB2B2_0009;
        write_burst(2, 3, 0);
        read_burst(1, 3, 0, 1'b0);
        read_burst(2, 3, 0, 1'b0);

        // Commands during a read burst and under self-refresh/power-down are dropped.
        read_burst(0, 8'hFE, 3, 1'b1);
        wait_ok();
        sr = 1'b1; cmd_en = 1'b1; cmd = 3'b101;
        repeat (4) @(negedge clk);
        sr = 1'b0; pd = 1'b1; cmd = 3'b010;
        repeat (4) @(negedge clk);
        cmd_en = 1'b0; pd = 1'b0;
        issue(3'b110, 21'h0, 8'd0, n);
        issue(3'b111, 21'h0, 8'd0, n);
        issue(3'b001, 21'h0, 8'd0, n);
        read_burst(0, 8'h40, 0, 1'b0);

        // Random traffic against the model.
        for (int it = 0; it < 30; it++) begin
            int bank, row, col, len, off, rlen;
            bank = int'($urandom_range(0, 3));
            row  = int'($urandom_range(0, 2047));
            col  = int'($urandom_range(0, 255));
            len  = int'($urandom_range(0, 7));
            activate(bank, row);
            for (int k = 0; k <= len; k++) begin wd[k] = $urandom; wm[k] = 4'h0; end
            write_burst(bank, col, len);
            for (int k = 0; k <= len; k++) begin wd[k] = $urandom; wm[k] = 4'($urandom_range(0, 15)); end
            write_burst(bank, col, len);
            if ($urandom_range(0, 1) == 1) issue(3'($urandom_range(0, 2)), 21'($urandom), 8'd0, n);
            off  = int'($urandom_range(0, len));
            rlen = int'($urandom_range(0, len - off));
            read_burst(bank, col + off, rlen, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a write burst: only the first word lands.
        activate(3, 11'h07);
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hC0DE_0000 + k; wm[k] = 4'h0; end
        write_burst(3, 8'h10, 3);
        wait_ok();
        issue(3'b100, {2'd3, 11'd0, 8'h10}, 8'd3, n);
        wdata = 32'hDEAD_0000; dqm = 4'h0;
        model_write(3, 8'h10, 32'hDEAD_0000, 4'h0);
        @(negedge clk);
        wdata = 32'hDEAD_0001;
        do_reset();
        activate(3, 11'h07);
        read_burst(3, 8'h10, 3, 1'b0);
        wait_ok();

        for (int t = 0; t < 200 && (rdq.size() > 0 || ackq.size() > 0); t++) @(negedge clk);
        if (rdq.size() > 0 || ackq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d reads and %0d acks still expected", rdq.size(), ackq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdrc_bram_responder.md
SDRC_BRAM_RESPONDER -- requirements
Module: sdrc_bram_responder

Purpose: block-RAM-backed responder on the SDRAM-controller user interface. Drop-in for the on-chip SDRAM controller so ramio runs unchanged in simulation and on builds without SDRAM.

Interface
REQ-001 SHALL have parameter AddressBitWidth, default 12, meaning log2 of the BRAM depth in 32-bit words.
REQ-002 SHALL have parameter InitCycles, default 16, meaning cycles from reset release to init_done.
REQ-003 SHALL have parameter CasLatency, default 2, meaning cycles from read ack to first read word.
REQ-004 SHALL have one clock and a synchronous, active-low reset; both ports are listed below.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have the following remaining ports:
- I_sdrc_cmd_en  input  1  command strobe.
- I_sdrc_cmd  input  3  command code.
- I_sdrc_precharge_ctrl  input  1  auto-precharge flag; functionally ignored.
- I_sdram_power_down  input  1  power-down request.
- I_sdram_selfrefresh  input  1  self-refresh request.
- I_sdrc_addr  input  21  {bank[20:19], row[18:8], col[7:0]}.
- I_sdrc_dqm  input  4  byte mask; bit i=1 masks byte i.
- I_sdrc_data  input  32  write data.
- I_sdrc_data_len  input  8  burst length minus one.
- O_sdrc_data  output  32  read data.
- O_sdrc_init_done  output  1  initialisation complete.
- O_sdrc_cmd_ack  output  1  one-cycle command acknowledge.

Function
REQ-006 SHALL use command codes 000 load-mode, 001 auto-refresh, 010 precharge, 011 active, 100 write, 101 read, 111 nop; code 110 SHALL be treated as nop.
REQ-007 SHALL hold O_sdrc_init_done low for exactly InitCycles cycles after rst_n is sampled high, then hold it high until the next reset.
REQ-008 SHALL implement FSM states INIT, IDLE, ACK, WRITE, READ_WAIT and READ.
REQ-009 SHALL accept a command only in IDLE with init_done=1, cmd_en=1, power_down=0 and selfrefresh=0; cmd_en in any other state or condition SHALL be ignored with no ack.
REQ-010 SHALL pulse O_sdrc_cmd_ack high for exactly one cycle at N+1 for a command accepted at cycle N, for every code except nop; nop SHALL produce no ack.
REQ-011 SHALL latch, on active, addr[18:8] into a per-bank row register selected by addr[20:19]; the four row registers reset to 0.
REQ-012 SHALL form the word address as {bank, row register of that bank, col} truncated to its low AddressBitWidth bits.
REQ-013 SHALL latch, on write accepted at cycle N, bank, col and data_len, then sample I_sdrc_data and I_sdrc_dqm on cycles N+1 .. N+1+data_len, writing word k to col+k.
REQ-014 SHALL, on write, update only bytes whose dqm bit is 0.
REQ-015 SHALL, on read accepted at cycle N, present word k (at col+k) on O_sdrc_data at cycle N+1+CasLatency+k for k = 0..data_len.
REQ-016 SHALL wrap the column index modulo 256 within the latched row during bursts; bank and row SHALL not increment.
REQ-017 SHALL hold O_sdrc_data at its last value outside read bursts.
REQ-018 SHALL treat load-mode, refresh and precharge as ack-only with no memory effect.
REQ-019 SHALL return to IDLE in the cycle after the last burst word, so a new command is accepted at the earliest in that cycle.
REQ-020 SHALL complete an in-flight burst if power_down or selfrefresh rises during it; those inputs block only new acceptance.
REQ-021 SHALL let a write burst followed immediately by a read to the same word return the newly written data.

Reset
REQ-022 SHALL, with rst_n=0 at a clock edge, enter INIT and clear init_done, cmd_ack, O_sdrc_data, the row registers and the init counter; BRAM contents need not be cleared.
REQ-023 SHALL abort any burst in progress on reset with no further memory writes after the reset edge.

Verification
REQ-024 SHALL be verified by these directed scenarios:
- Reset then idle -> init_done rises exactly 16 cycles after rst_n high; cmd_en before then gives no ack.
- Active 0x0_0A5, then write len=3 data 0x11111111..0x44444444 at col 0xFE, then read len=3 -> read returns words in order; cols FE, FF, 00, 01 wrap within the row; first word at ack+2.
- Write 0xAABBCCDD with dqm=4'b0101 over 0x00000000, then read -> 0xAA00CC00.
- Active bank 1 row 5 and bank 2 row 9; write col 3 to each bank; read back -> distinct values, no aliasing.
- cmd_en held during a read burst, and a command with selfrefresh=1 -> neither acked; burst data unchanged.
- Reset asserted mid-write burst at word 1 -> only word 0 written; init_done drops and re-rises after 16 cycles.
